// File: rtl/imem_dmem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, port-owner encoding and
// the all-ones byte-enable constant used for instruction fetches.
package imem_dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbState_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Wide enough for any supported DATA_W; callers slice to DATA_W/8.
  localparam logic [127:0] BE_ALL = '1;

  function automatic owner_e ownerOf(arbState_e s);
    unique case (s)
      BUSY_I:  return OWN_I;
      BUSY_D:  return OWN_D;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Busy-cycle counter for the port arbiter abort path; instantiated only when ARB_TIMEOUT_EN
// is defined. tc is high during the LIMIT-th busy cycle.
module arb_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [CntW-1:0] cntQ;

  assign tc = en && (cntQ == CntW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntQ <= '0;
    end else if (clr) begin
      cntQ <= '0;
    end else if (en && !tc) begin
      cntQ <= cntQ + CntW'(1);
    end
  end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and data requesters, one
// transaction at a time. Optional abort on a hung memory via ARB_TIMEOUT_EN.
module imem_dmem_port_arbiter
  import imem_dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  output logic                if_err,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                dm_err,
  output logic                stall_f,
  output logic                stall_m,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam int unsigned BE_W = DATA_W / 8;

  arbState_e stateQ, stateD;
  owner_e    owner;
  logic      grantI, grantD, finish, abort, busy, timeoutHit;
  logic      ifElig, dmElig;

  logic              memReqQ, memWeQ;
  logic [ADDR_W-1:0] memAddrQ;
  logic [DATA_W-1:0] memWdataQ, ifRdataQ, dmRdataQ;
  logic [BE_W-1:0]   memBeQ;
  logic              ifReadyQ, dmReadyQ, ifErrQ, dmErrQ;

  // A requester whose ready is high this cycle is still showing its finished request.
  assign ifElig = if_req && !ifReadyQ;
  assign dmElig = dm_req && !dmReadyQ;
  assign busy   = (stateQ != IDLE);
  assign owner  = ownerOf(stateQ);

`ifdef ARB_TIMEOUT_EN
  arb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk(clk),
    .rst(rst),
    .clr(grantI | grantD),
    .en (busy),
    .tc (timeoutHit)
  );
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
  assign timeoutHit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateQ <= IDLE;
    else      stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    grantI = 1'b0;
    grantD = 1'b0;
    finish = 1'b0;
    abort  = 1'b0;
    unique case (stateQ)
      IDLE: begin
        // Data side belongs to the older instruction, so it wins a collision.
        if (dmElig) begin
          grantD = 1'b1;
          stateD = BUSY_D;
        end else if (ifElig) begin
          grantI = 1'b1;
          stateD = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          finish = 1'b1;
          stateD = IDLE;
        end else if (timeoutHit) begin
          abort  = 1'b1;
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      memBeQ    <= '0;
      ifRdataQ  <= '0;
      dmRdataQ  <= '0;
      ifReadyQ  <= 1'b0;
      dmReadyQ  <= 1'b0;
      ifErrQ    <= 1'b0;
      dmErrQ    <= 1'b0;
    end else begin
      ifReadyQ <= 1'b0;
      dmReadyQ <= 1'b0;
      ifErrQ   <= 1'b0;
      dmErrQ   <= 1'b0;
      if (grantD) begin
        memReqQ   <= 1'b1;
        memWeQ    <= dm_we;
        memAddrQ  <= dm_addr;
        memWdataQ <= dm_wdata;
        memBeQ    <= dm_be;
      end else if (grantI) begin
        memReqQ   <= 1'b1;
        memWeQ    <= 1'b0;
        memAddrQ  <= if_addr;
        memWdataQ <= '0;
        memBeQ    <= BE_ALL[BE_W-1:0];
      end
      if (finish || abort) begin
        memReqQ <= 1'b0;
        if (owner == OWN_I) begin
          ifReadyQ <= 1'b1;
          ifErrQ   <= abort;
          ifRdataQ <= finish ? mem_rdata : '0;
        end else begin
          dmReadyQ <= 1'b1;
          dmErrQ   <= abort;
          dmRdataQ <= finish ? mem_rdata : '0;
        end
      end
    end
  end

  assign mem_req   = memReqQ;
  assign mem_we    = memWeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;
  assign mem_be    = memBeQ;
  assign if_rdata  = ifRdataQ;
  assign dm_rdata  = dmRdataQ;
  assign if_ready  = ifReadyQ;
  assign dm_ready  = dmReadyQ;
  assign if_err    = ifErrQ;
  assign dm_err    = dmErrQ;
  assign stall_f   = if_req && !ifReadyQ;
  assign stall_m   = dm_req && !dmReadyQ;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Scoreboard bench for imem_dmem_port_arbiter: stimulus pushes expected grants and responses,
// a negedge monitor pops and compares. Define ARB_TIMEOUT_EN to add the abort scenario.
module tb_imem_dmem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0, mem_addr;
  logic [DW-1:0] dm_wdata = '0, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [BW-1:0] dm_be = '0, mem_be;
  logic          if_ready, if_err, dm_ready, dm_err, stall_f, stall_m;
  logic          mem_req, mem_we, mem_ack;

  always #5 clk = ~clk;

  imem_dmem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_err(dm_err),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } grant_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  grant_t expGrant[$];
  resp_t  expIf[$];
  resp_t  expDm[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int memWait = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] memModel(input logic [AW-1:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00A00113;
      32'h8:   return 32'h002081B3;
      32'h100: return 32'h12345678;
      default: return {16'hCAFE, a[15:0]};
    endcase
  endfunction

  function automatic grant_t mkGrant(input logic [AW-1:0] a, input logic we,
                                     input logic [DW-1:0] wd, input logic [BW-1:0] be);
    grant_t g;
    g.addr = a; g.we = we; g.wdata = wd; g.be = be;
    return g;
  endfunction

  function automatic resp_t mkResp(input logic [DW-1:0] d, input logic e);
    resp_t r;
    r.rdata = d; r.err = e;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: ack after memWait cycles of mem_req without ack; memWait=0 acks in the
  // first cycle mem_req is seen.
  initial begin : memory
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || !mem_req) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (cnt >= memWait) begin
        mem_ack = 1'b1;
        mem_rdata = memModel(mem_addr);
      end else begin
        cnt++;
      end
    end
  end

  initial begin : monitor
    grant_t cur, held, g;
    resp_t  r;
    bit     prevReq, prevIfR, prevDmR;
    prevReq = 0; prevIfR = 0; prevDmR = 0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prevReq = 0; prevIfR = 0; prevDmR = 0;
      end else begin
        cur = mkGrant(mem_addr, mem_we, mem_wdata, mem_be);
        if (mem_req && !prevReq) begin
          if (expGrant.size() == 0) check("grant_unexpected", 1, 0);
          else begin
            g = expGrant.pop_front();
            check("grant_addr", mem_addr, g.addr);
            check("grant_we", mem_we, g.we);
            check("grant_be", mem_be, g.be);
            if (g.we) check("grant_wdata", mem_wdata, g.wdata);
          end
          held = cur;
        end else if (mem_req) begin
          check("mem_stable", cur, held);
        end
        prevReq = mem_req;
        if (if_ready) begin
          check("if_single_pulse", prevIfR, 0);
          if (expIf.size() == 0) check("if_ready_unexpected", 1, 0);
          else begin
            r = expIf.pop_front();
            check("if_rdata", if_rdata, r.rdata);
            check("if_err", if_err, r.err);
          end
        end
        if (dm_ready) begin
          check("dm_single_pulse", prevDmR, 0);
          if (expDm.size() == 0) check("dm_ready_unexpected", 1, 0);
          else begin
            r = expDm.pop_front();
            check("dm_rdata", dm_rdata, r.rdata);
            check("dm_err", dm_err, r.err);
          end
        end
        prevIfR = if_ready;
        prevDmR = dm_ready;
      end
    end
  end

  task automatic waitFor(input string name, input bit isDm, input int limit,
                         input bit chkStallF, output bit seen);
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (isDm ? dm_ready : if_ready) seen = 1;
      else if (chkStallF) check({name, "_stall_f"}, stall_f, 1);
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end, want $finish");
    $fatal(1);
  end

  initial begin : stimulus
    bit seen;
    int lastCyc, startCyc;
    logic [AW-1:0] fetchAddr[3];
    fetchAddr[0] = 32'h0; fetchAddr[1] = 32'h4; fetchAddr[2] = 32'h8;

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_readys", {if_ready, dm_ready, if_err, dm_err}, 0);
    check("rst_rdata", {if_rdata, dm_rdata}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait fetch stream, req held through each ready cycle.
    memWait = 0;
    for (int k = 0; k < 3; k++) begin
      expGrant.push_back(mkGrant(fetchAddr[k], 1'b0, '0, 4'hF));
      expIf.push_back(mkResp(memModel(fetchAddr[k]), 1'b0));
    end
    if_req = 1'b1;
    if_addr = fetchAddr[0];
    for (int k = 0; k < 3; k++) begin
      waitFor("fetch", 1'b0, 10, 1'b1, seen);
      if (k > 0) check("fetch_spacing", cyc - lastCyc, 3);
      lastCyc = cyc;
      if (k < 2) if_addr = fetchAddr[k+1];
      else       if_req = 1'b0;
    end
    @(negedge clk);

    // Collision: data load wins, fetch follows.
    expGrant.push_back(mkGrant(32'h100, 1'b0, '0, 4'hF));
    expGrant.push_back(mkGrant(32'hC, 1'b0, '0, 4'hF));
    expDm.push_back(mkResp(32'h12345678, 1'b0));
    expIf.push_back(mkResp(32'hCAFE000C, 1'b0));
    if_req = 1'b1; if_addr = 32'hC;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_be = 4'hF; dm_wdata = '0;
    waitFor("coll_dm", 1'b1, 10, 1'b1, seen);
    check("coll_if_not_first", if_ready, 0);
    dm_req = 1'b0;
    waitFor("coll_if", 1'b0, 10, 1'b0, seen);
    if_req = 1'b0;
    @(negedge clk);

    // Store with 5 wait states, fetch stalled behind it; dm_req held through its ready cycle.
    memWait = 5;
    expGrant.push_back(mkGrant(32'h200, 1'b1, 32'hDEADBEEF, 4'b0011));
    expGrant.push_back(mkGrant(32'h10, 1'b0, '0, 4'hF));
    expDm.push_back(mkResp(32'hCAFE0200, 1'b0));
    expIf.push_back(mkResp(32'hCAFE0010, 1'b0));
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    if_req = 1'b1; if_addr = 32'h10;
    waitFor("store", 1'b1, 20, 1'b1, seen);
    check("store_stall_m_ready", stall_m, 0);
    @(negedge clk);
    dm_req = 1'b0; dm_we = 1'b0;
    waitFor("store_if", 1'b0, 20, 1'b0, seen);
    if_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a long store.
    memWait = 50;
    expGrant.push_back(mkGrant(32'h300, 1'b1, 32'h11112222, 4'hF));
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'h11112222; dm_be = 4'hF;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    check("mid_grant_seen", seen, 1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_mem", {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, 0);
    check("mid_rst_rdata", {if_rdata, dm_rdata}, 0);
    check("mid_rst_flags", {if_ready, dm_ready, if_err, dm_err}, 0);
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_mem_req", mem_req, 0);

    memWait = 0;
    expGrant.push_back(mkGrant(32'h4, 1'b0, '0, 4'hF));
    expIf.push_back(mkResp(32'h00A00113, 1'b0));
    if_req = 1'b1; if_addr = 32'h4;
    waitFor("post_rst_fetch", 1'b0, 10, 1'b0, seen);
    if_req = 1'b0;
    @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // Memory never acks: abort after 4 busy cycles with zeroed data and err.
    memWait = 1000;
    expGrant.push_back(mkGrant(32'h400, 1'b0, '0, 4'hF));
    expDm.push_back(mkResp('0, 1'b1));
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_be = 4'hF; dm_wdata = '0;
    seen = 0;
    startCyc = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    startCyc = cyc;
    waitFor("timeout", 1'b1, 20, 1'b0, seen);
    check("timeout_cycles", cyc - startCyc, 4);
    check("timeout_mem_req", mem_req, 0);
    dm_req = 1'b0;
    memWait = 0;
    @(negedge clk);
`else
    startCyc = 0;
`endif

    repeat (4) @(negedge clk);
    check("grant_queue_empty", expGrant.size(), 0);
    check("if_queue_empty", expIf.size(), 0);
    check("dm_queue_empty", expDm.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
